// File: rtl/procesador_control_calculo_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for the
// calculation-control slave.
package procesador_ctrl_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PARAM  = 2'd1;
  localparam logic [1:0] ADDR_CYCLES = 2'd2;
  localparam logic [1:0] ADDR_IRQEN  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_e;
endpackage

// File: rtl/procesador_control_calculo_if.sv
// Avalon-MM slave bus between the Nios interconnect and the calculation control block.
interface procesador_control_calculo_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/procesador_control_calculo_edge.sv
// Rising-edge detector for the fabric completion level; the delay flop
// clears on reset so a level already high afterwards reads as an edge.
module procesador_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q, d_d;

  always_comb d_d = d;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d_d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/procesador_control_calculo.sv
// Nios-facing control slave: latches a parameter, pulses start to the fabric,
// times the busy interval and reports completion through a sticky flag / irq.
module procesador_control_calculo
  import procesador_ctrl_pkg::*;
#(
  parameter int PARAM_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  procesador_control_calculo_if.slave   bus,
  input  logic                          calc_done,
  output logic                          start_pulse,
  output logic [PARAM_W-1:0]            param_out,
  output logic                          busy,
  output logic                          irq
);
  state_e               state_q, state_d;
  logic [PARAM_W-1:0]   param_q, param_d, param_out_q, param_out_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d, irqen_q, irqen_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rise, wr;

  procesador_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (calc_done),
    .rise  (rise)
  );

  assign wr = bus.chipselect & ~bus.write_n;

  always_comb begin
    state_d     = state_q;
    param_d     = param_q;
    param_out_d = param_out_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    irqen_d     = irqen_q;

    if (wr && bus.address == ADDR_PARAM) param_d = bus.writedata[PARAM_W-1:0];
    if (wr && bus.address == ADDR_IRQEN) irqen_d = bus.writedata[0];
    if (wr && bus.address == ADDR_CTRL && bus.writedata[CTRL_CLR]) done_d = 1'b0;

    // A completion in the same cycle as a clear-done write overrides the clear.
    unique case (state_q)
      S_IDLE: begin
        if (wr && bus.address == ADDR_CTRL && bus.writedata[CTRL_START]) begin
          state_d     = S_START;
          param_out_d = param_q;
          cnt_d       = '0;
          done_d      = 1'b0;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (rise) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdata_d = '0;
    unique case (bus.address)
      ADDR_CTRL: begin
        rdata_d[ST_BUSY] = (state_q != S_IDLE);
        rdata_d[ST_DONE] = done_q;
      end
      ADDR_PARAM:  rdata_d = 32'(param_q);
      ADDR_CYCLES: rdata_d = 32'(cnt_q);
      ADDR_IRQEN:  rdata_d[0] = irqen_q;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      param_q     <= '0;
      param_out_q <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      irqen_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      param_q     <= param_d;
      param_out_q <= param_out_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      irqen_q     <= irqen_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign start_pulse  = (state_q == S_START);
  assign busy         = (state_q != S_IDLE);
  assign param_out    = param_out_q;
  assign irq          = done_q & irqen_q;
endmodule

// File: tb/tb_procesador_control_calculo.sv
// Self-checking bench: register table, directed corner sequences and randomized
// calculations compared against a transaction-level expectation.
module tb_procesador_control_calculo;
  import procesador_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        calc_done, calc_done4;
  logic        start_pulse, busy, irq, start_pulse4, busy4, irq4;
  logic [31:0] param_out, param_out4;
  int          n_chk = 0, n_fail = 0, pulses = 0, exp_pulses = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  procesador_control_calculo_if bus0();
  procesador_control_calculo_if bus4();

  procesador_control_calculo #(.PARAM_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus0), .calc_done(calc_done),
    .start_pulse(start_pulse), .param_out(param_out), .busy(busy), .irq(irq)
  );

  procesador_control_calculo #(.PARAM_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .calc_done(calc_done4),
    .start_pulse(start_pulse4), .param_out(param_out4), .busy(busy4), .irq(irq4)
  );

  // Pulses of the main DUT, counted on the edge that consumes them.
  always @(posedge clk) if (start_pulse) pulses++;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = d;
    @(negedge clk);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus0.address = a;
    @(negedge clk);
    d = bus0.readdata;
  endtask

  vec_t vt[6];

  initial begin
    bus0.address = 0; bus0.chipselect = 0; bus0.write_n = 1; bus0.writedata = 0;
    bus4.address = 0; bus4.chipselect = 0; bus4.write_n = 1; bus4.writedata = 0;
    calc_done = 0; calc_done4 = 0;

    // Reset values
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst start_pulse", {31'b0, start_pulse}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst irq", {31'b0, irq}, 0);
    chk("rst param_out", param_out, 0);
    chk("rst readdata", bus0.readdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), rv);
      chk($sformatf("rst read addr%0d", i), rv, 0);
    end

    // Register access table
    vt[0] = '{ADDR_PARAM,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[1] = '{ADDR_IRQEN,  32'hFFFFFFFF, 32'h1};
    vt[2] = '{ADDR_CYCLES, 32'h0000ABCD, 32'h0};
    vt[3] = '{ADDR_CTRL,   32'hFFFFFFFC, 32'h0};
    vt[4] = '{ADDR_IRQEN,  32'hFFFFFFFE, 32'h0};
    vt[5] = '{ADDR_PARAM,  32'h00000000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      wr(vt[i].a, vt[i].wd);
      rd(vt[i].a, rv);
      chk($sformatf("table[%0d] read", i), rv, vt[i].exp);
    end
    chk("table no pulse", pulses, 0);

    // Normal calculation, completion 3 busy cycles after the pulse
    wr(ADDR_PARAM, 32'h1234);
    wr(ADDR_IRQEN, 32'h1);
    wr(ADDR_CTRL, 32'h1); exp_pulses++;
    chk("norm start_pulse", {31'b0, start_pulse}, 1);
    chk("norm busy at pulse", {31'b0, busy}, 1);
    chk("norm param_out at pulse", param_out, 32'h1234);
    repeat (3) begin
      @(negedge clk);
      chk("norm pulse low in busy", {31'b0, start_pulse}, 0);
      chk("norm param_out in busy", param_out, 32'h1234);
    end
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    chk("norm busy done", {31'b0, busy}, 0);
    chk("norm irq", {31'b0, irq}, 1);
    chk("norm one pulse", pulses, exp_pulses);
    rd(ADDR_CTRL, rv);   chk("norm status", rv, 32'h2);
    rd(ADDR_CYCLES, rv); chk("norm cycles", rv, 3);
    wr(ADDR_CTRL, 32'h2);
    chk("norm irq cleared", {31'b0, irq}, 0);
    rd(ADDR_CTRL, rv);   chk("norm status cleared", rv, 0);

    // Writes while busy; then start+clear from IDLE with done set
    wr(ADDR_CTRL, 32'h1); exp_pulses++;
    wr(ADDR_CTRL, 32'h1);
    wr(ADDR_PARAM, 32'hBEEF);
    rd(ADDR_PARAM, rv);  chk("busy param shadow", rv, 32'hBEEF);
    chk("busy param_out held", param_out, 32'h1234);
    chk("busy no second pulse", pulses, exp_pulses);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    chk("busy completes", {31'b0, busy}, 0);
    wr(ADDR_CTRL, 32'h3); exp_pulses++;
    chk("startclr param_out", param_out, 32'hBEEF);
    rd(ADDR_CTRL, rv);   chk("startclr status", rv, 32'h1);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;

    // Rise and clear-done in the same cycle: set wins
    wr(ADDR_CTRL, 32'h1); exp_pulses++;
    @(negedge clk);
    calc_done = 1'b1;
    wr(ADDR_CTRL, 32'h2);
    calc_done = 1'b0;
    chk("setclr busy", {31'b0, busy}, 0);
    chk("setclr irq", {31'b0, irq}, 1);
    rd(ADDR_CTRL, rv);   chk("setclr status", rv, 32'h2);
    wr(ADDR_CTRL, 32'h2);

    // calc_done already high at start needs a fresh edge
    calc_done = 1'b1;
    @(negedge clk);
    wr(ADDR_CTRL, 32'h1); exp_pulses++;
    repeat (5) @(negedge clk);
    chk("high-at-start still busy", {31'b0, busy}, 1);
    calc_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("high-at-start after drop", {31'b0, busy}, 1);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    chk("high-at-start new edge", {31'b0, busy}, 0);
    rd(ADDR_CYCLES, rv); chk("high-at-start cycles", rv, 7);
    wr(ADDR_CTRL, 32'h2);

    // Counter saturation on the 4-bit instance
    bus4.address = ADDR_CTRL; bus4.chipselect = 1'b1; bus4.write_n = 1'b0; bus4.writedata = 32'h1;
    @(negedge clk);
    bus4.chipselect = 1'b0; bus4.write_n = 1'b1;
    chk("sat pulse", {31'b0, start_pulse4}, 1);
    repeat (20) @(negedge clk);
    chk("sat still busy", {31'b0, busy4}, 1);
    calc_done4 = 1'b1;
    @(negedge clk);
    calc_done4 = 1'b0;
    chk("sat done", {31'b0, busy4}, 0);
    bus4.address = ADDR_CYCLES;
    @(negedge clk);
    chk("sat cycles", bus4.readdata, 32'hF);

    // Reset mid-calculation
    wr(ADDR_PARAM, 32'h77);
    wr(ADDR_CTRL, 32'h1); exp_pulses++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst irq", {31'b0, irq}, 0);
    chk("midrst param_out", param_out, 0);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    chk("midrst edge ignored", {31'b0, busy}, 0);
    rd(ADDR_CTRL, rv);   chk("midrst status", rv, 0);
    rd(ADDR_PARAM, rv);  chk("midrst param", rv, 0);
    wr(ADDR_PARAM, 32'h55);
    wr(ADDR_CTRL, 32'h1); exp_pulses++;
    chk("midrst restart param_out", param_out, 32'h55);
    repeat (2) @(negedge clk);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    chk("midrst restart done", {31'b0, busy}, 0);
    rd(ADDR_CYCLES, rv); chk("midrst restart cycles", rv, 2);
    rd(ADDR_CTRL, rv);   chk("midrst restart status", rv, 32'h2);

    // Randomized calculations: expectations come from the transaction itself
    for (int it = 0; it < 25; it++) begin
      logic [31:0] prm, en_w, ctl;
      int          k;
      prm  = $urandom;
      en_w = $urandom;
      k    = $urandom_range(1, 40);
      ctl  = ($urandom_range(0, 1) != 0) ? 32'h3 : 32'h1;
      wr(ADDR_PARAM, prm);
      wr(ADDR_IRQEN, en_w);
      wr(ADDR_CTRL, ctl); exp_pulses++;
      chk("rnd param_out", param_out, prm);
      chk("rnd irq during calc", {31'b0, irq}, 0);
      repeat (k) @(negedge clk);
      calc_done = 1'b1;
      @(negedge clk);
      calc_done = 1'b0;
      chk("rnd busy", {31'b0, busy}, 0);
      chk("rnd irq", {31'b0, irq}, {31'b0, en_w[0]});
      rd(ADDR_CYCLES, rv); chk($sformatf("rnd cycles k=%0d", k), rv, 32'(k));
      rd(ADDR_CTRL, rv);   chk("rnd status", rv, 32'h2);
      rd(ADDR_IRQEN, rv);  chk("rnd irqen", rv, {31'b0, en_w[0]});
      if ($urandom_range(0, 1) != 0) begin
        wr(ADDR_CTRL, 32'h2);
        chk("rnd clear irq", {31'b0, irq}, 0);
      end
    end
    @(negedge clk);
    chk("total pulses", pulses, exp_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
